// File: rtl/btb_pkg.sv
// Shared types and entry layout helpers for the branch target buffer.
package btb_pkg;

    // 2-bit direction counter encodings
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } cnt_t;

    // Sequencer states: INIT sweeps valid/LRU bits, RUN serves lookups/updates
    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int CNT_W   = 2;
    localparam int CNT_LSB = 0;
    localparam int TGT_LSB = CNT_LSB + CNT_W;

    // Entry word layout, LSB first: counter | target | tag
    function automatic int tag_w(int pc_w, int idx_w);
        return pc_w - idx_w;
    endfunction

    function automatic int tag_lsb(int pc_w);
        return TGT_LSB + pc_w;
    endfunction

    function automatic int entry_w(int pc_w, int idx_w);
        return CNT_W + pc_w + tag_w(pc_w, idx_w);
    endfunction

    // Saturating counter steps: never wrap 3->0 or 0->3
    function automatic logic [1:0] cnt_inc(logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] cnt_dec(logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: valid bits in flops (so the init sweep can clear
// them one set per cycle) plus an entry array with two async read ports
// and one synchronous write port.
module btb_way
    import btb_pkg::*;
#(
    parameter int PC_W  = 13,
    parameter int IDX_W = 9
) (
    input  logic                              clk,
    input  logic                              clr_en,
    input  logic [IDX_W-1:0]                  clr_idx,
    input  logic [IDX_W-1:0]                  lk_idx,
    output logic                              lk_valid,
    output logic [entry_w(PC_W, IDX_W)-1:0]   lk_data,
    input  logic [IDX_W-1:0]                  up_idx,
    output logic                              up_valid,
    output logic [entry_w(PC_W, IDX_W)-1:0]   up_data,
    input  logic                              wr_en,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic [entry_w(PC_W, IDX_W)-1:0]   wr_data
);

    localparam int SETS = 1 << IDX_W;
    localparam int EW   = entry_w(PC_W, IDX_W);

    logic [SETS-1:0] valid;
    logic [EW-1:0]   mem [SETS];

    // Valid bits: sweep clear and allocation never overlap (INIT vs RUN)
    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Entry payload storage, write-synchronous
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign lk_valid = valid[lk_idx];
    assign lk_data  = mem[lk_idx];
    assign up_valid = valid[up_idx];
    assign up_data  = mem[up_idx];

endmodule

// File: rtl/btb_predict.sv
// 2-way set-associative branch target buffer with 2-bit saturating
// direction counters. Holds the init sequencer, per-set LRU bits,
// hit/replacement logic and the registered lookup outputs.
//
// state  | meaning
// S_INIT | clearing valid + LRU bits of one set per cycle, outputs forced to miss
// S_RUN  | lookups and updates live
module btb_predict
    import btb_pkg::*;
#(
    parameter int         PC_W     = 13,
    parameter int         IDX_W    = 9,
    parameter logic [1:0] CNT_INIT = 2'b10
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] pcF,
    output logic            hit_predict,
    output logic            pred_taken,
    output logic [PC_W-1:0] prepc,
    output logic            ready,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int SETS   = 1 << IDX_W;
    localparam int TAG_W  = tag_w(PC_W, IDX_W);
    localparam int EW     = entry_w(PC_W, IDX_W);
    localparam int TG_LSB = tag_lsb(PC_W);
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] sweep_idx;
    logic             sweep_en;
    logic             live;
    logic [SETS-1:0]  lru;

    // ---------------- FSM ----------------

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_INIT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: leave INIT once the last set has been cleared
    always_comb begin
        state_nx = state;
        if (state == S_INIT && sweep_idx == LAST_IDX) begin
            state_nx = S_RUN;
        end
    end

    // FSM outputs
    always_comb begin
        ready    = 1'b0;
        sweep_en = 1'b0;
        live     = 1'b0;
        case (state)
            S_INIT: sweep_en = !RST;
            S_RUN: begin
                ready = 1'b1;
                live  = !RST;
            end
            default: ;
        endcase
    end

    // Sweep index: restarts at 0 on reset, advances one set per INIT cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            sweep_idx <= '0;
        end else if (state == S_INIT) begin
            sweep_idx <= sweep_idx + IDX_W'(1);
        end
    end

    // ---------------- Ways ----------------

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic [1:0]       lk_valid;
    logic [1:0]       up_valid;
    logic [EW-1:0]    lk_data [2];
    logic [EW-1:0]    up_data [2];
    logic [1:0]       wr_en;
    logic [EW-1:0]    wr_data;

    assign lk_idx = pcF[IDX_W-1:0];
    assign lk_tag = pcF[PC_W-1:IDX_W];
    assign up_idx = upd_pc[IDX_W-1:0];
    assign up_tag = upd_pc[PC_W-1:IDX_W];

    btb_way #(.PC_W(PC_W), .IDX_W(IDX_W)) u_way0 (
        .clk      (CLK),
        .clr_en   (sweep_en),
        .clr_idx  (sweep_idx),
        .lk_idx   (lk_idx),
        .lk_valid (lk_valid[0]),
        .lk_data  (lk_data[0]),
        .up_idx   (up_idx),
        .up_valid (up_valid[0]),
        .up_data  (up_data[0]),
        .wr_en    (wr_en[0]),
        .wr_idx   (up_idx),
        .wr_data  (wr_data)
    );

    btb_way #(.PC_W(PC_W), .IDX_W(IDX_W)) u_way1 (
        .clk      (CLK),
        .clr_en   (sweep_en),
        .clr_idx  (sweep_idx),
        .lk_idx   (lk_idx),
        .lk_valid (lk_valid[1]),
        .lk_data  (lk_data[1]),
        .up_idx   (up_idx),
        .up_valid (up_valid[1]),
        .up_data  (up_data[1]),
        .wr_en    (wr_en[1]),
        .wr_idx   (up_idx),
        .wr_data  (wr_data)
    );

    // ---------------- Lookup ----------------

    logic [1:0]      lk_hit;
    logic [EW-1:0]   lk_sel;

    // Tag compare; a double hit cannot arise from legal updates, way 0 wins
    always_comb begin
        lk_hit[0] = lk_valid[0] && (lk_data[0][TG_LSB +: TAG_W] == lk_tag);
        lk_hit[1] = lk_valid[1] && (lk_data[1][TG_LSB +: TAG_W] == lk_tag);
        lk_sel    = lk_hit[0] ? lk_data[0] : lk_data[1];
    end

    // Registered prediction; reads see pre-update contents (no bypass)
    always_ff @(posedge CLK) begin
        if (RST || !(state == S_RUN) || lk_hit == 2'b00) begin
            hit_predict <= 1'b0;
            pred_taken  <= 1'b0;
            prepc       <= '0;
        end else begin
            hit_predict <= 1'b1;
            pred_taken  <= lk_sel[CNT_LSB + 1];
            prepc       <= lk_sel[TGT_LSB +: PC_W];
        end
    end

    // ---------------- Update ----------------

    logic [1:0]      up_hit;
    logic            up_any;
    logic            up_way;
    logic            wr_go;
    logic [EW-1:0]   old_data;
    logic [1:0]      new_cnt;
    logic [PC_W-1:0] new_tgt;

    // Hit/replace selection and new entry contents for the update port
    always_comb begin
        up_hit[0] = up_valid[0] && (up_data[0][TG_LSB +: TAG_W] == up_tag);
        up_hit[1] = up_valid[1] && (up_data[1][TG_LSB +: TAG_W] == up_tag);
        up_any    = |up_hit;
        if (up_hit[0]) begin
            up_way = 1'b0;
        end else if (up_hit[1]) begin
            up_way = 1'b1;
        end else begin
            up_way = lru[up_idx];
        end
        old_data = up_way ? up_data[1] : up_data[0];
        if (up_any) begin
            new_cnt = upd_taken ? cnt_inc(old_data[CNT_LSB +: CNT_W])
                                : cnt_dec(old_data[CNT_LSB +: CNT_W]);
        end else begin
            new_cnt = CNT_INIT;
        end
        new_tgt  = upd_taken ? upd_target : old_data[TGT_LSB +: PC_W];
        wr_data  = {up_tag, new_tgt, new_cnt};
        wr_go    = live && upd_en && (up_any || upd_taken);
        wr_en[0] = wr_go && !up_way;
        wr_en[1] = wr_go && up_way;
    end

    // LRU bit names the least-recent way; any write points it at the other way
    always_ff @(posedge CLK) begin
        if (sweep_en) begin
            lru[sweep_idx] <= 1'b0;
        end else if (wr_go) begin
            lru[up_idx] <= ~up_way;
        end
    end

endmodule

// File: tb/tb_btb_predict.sv
// Scoreboard bench for btb_predict: a per-set reference model computes each
// expected prediction when the stimulus is issued; a monitor compares after
// every clock edge.
module tb_btb_predict;

    localparam int PC_W  = 13;
    localparam int IDX_W = 9;
    localparam int SETS  = 1 << IDX_W;

    logic            CLK = 1'b0;
    logic            RST;
    logic [PC_W-1:0] pcF;
    logic            hit_predict;
    logic            pred_taken;
    logic [PC_W-1:0] prepc;
    logic            ready;
    logic            upd_en;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;

    always #5 CLK = ~CLK;

    btb_predict #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_INIT(2'b10)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .pcF         (pcF),
        .hit_predict (hit_predict),
        .pred_taken  (pred_taken),
        .prepc       (prepc),
        .ready       (ready),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken)
    );

    typedef struct {
        logic            hit;
        logic            taken;
        logic [PC_W-1:0] pc;
        logic            rdy;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: per set, two ways plus the index of the least-recent way
    bit m_valid [SETS][2];
    int m_tag   [SETS][2];
    int m_tgt   [SETS][2];
    int m_cnt   [SETS][2];
    int m_lru   [SETS];
    int init_left = 0;

    function automatic int find_way(int s, int t);
        if (m_valid[s][0] && m_tag[s][0] == t) return 0;
        if (m_valid[s][1] && m_tag[s][1] == t) return 1;
        return -1;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_valid[s][0] = 1'b0;
            m_valid[s][1] = 1'b0;
            m_lru[s] = 0;
        end
    endfunction

    function automatic void model_update(int pc, int tgt, bit tk);
        int s, t, w;
        s = pc % SETS;
        t = pc / SETS;
        w = find_way(s, t);
        if (w >= 0) begin
            if (tk) begin
                m_cnt[s][w] = (m_cnt[s][w] == 3) ? 3 : m_cnt[s][w] + 1;
                m_tgt[s][w] = tgt;
            end else begin
                m_cnt[s][w] = (m_cnt[s][w] == 0) ? 0 : m_cnt[s][w] - 1;
            end
            m_lru[s] = 1 - w;
        end else if (tk) begin
            w = m_lru[s];
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = t;
            m_tgt[s][w]   = tgt;
            m_cnt[s][w]   = 2;
            m_lru[s]      = 1 - w;
        end
    endfunction

    // One clock of stimulus: lookup pc, optional update, optional reset
    task automatic step(bit rst, int pc, bit ue, int upc, int utgt, bit utk);
        exp_t e;
        int s, t, w;
        logic [PC_W-1:0] pcv, upcv, utgtv;
        @(negedge CLK);
        pcv   = pc[PC_W-1:0];
        upcv  = upc[PC_W-1:0];
        utgtv = utgt[PC_W-1:0];
        RST        = rst;
        pcF        = pcv;
        upd_en     = ue;
        upd_pc     = upcv;
        upd_target = utgtv;
        upd_taken  = utk;
        e.hit   = 1'b0;
        e.taken = 1'b0;
        e.pc    = '0;
        e.rdy   = 1'b0;
        if (rst) begin
            model_clear();
            init_left = SETS;
        end else begin
            s = int'(pcv) % SETS;
            t = int'(pcv) / SETS;
            w = find_way(s, t);
            if (init_left == 0 && w >= 0) begin
                e.hit   = 1'b1;
                e.taken = (m_cnt[s][w] >= 2);
                e.pc    = m_tgt[s][w][PC_W-1:0];
            end
            e.rdy = (init_left <= 1);
            if (init_left == 0 && ue) model_update(int'(upcv), int'(utgtv), utk);
            if (init_left > 0) init_left--;
        end
        sbq.push_back(e);
    endtask

    task automatic look(int pc);
        step(1'b0, pc, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic upd(int pc, int tgt, bit tk);
        step(1'b0, 32'h1ABC, 1'b1, pc, tgt, tk);
    endtask

    // Monitor: one response per clock edge once stimulus is flowing
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_tests++;
                if (hit_predict !== e.hit || pred_taken !== e.taken ||
                    prepc !== e.pc || ready !== e.rdy) begin
                    n_fail++;
                    $display("FAIL lookup %0d @%0t: actual hit=%0b taken=%0b prepc=0x%04h ready=%0b, required hit=%0b taken=%0b prepc=0x%04h ready=%0b",
                             n_tests, $time, hit_predict, pred_taken, prepc, ready,
                             e.hit, e.taken, e.pc, e.rdy);
                end
            end
        end
    end

    int idx_pool [5] = '{32'h000, 32'h104, 32'h1FF, 32'h055, 32'h0AA};

    function automatic int rand_pc();
        int idx;
        idx = idx_pool[$urandom_range(4, 0)];
        return ($urandom_range(15, 0) * SETS) + idx;
    endfunction

    initial begin
        RST = 1'b0; pcF = '0; upd_en = 1'b0;
        upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        repeat (2) @(posedge CLK);

        // Reset and initial sweep; updates during INIT must be dropped
        step(1'b1, 0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < SETS; i++) begin
            case (i % 3)
                0: step(1'b0, 32'h0000, (i % 7 == 0), 32'h0104, 32'h0777, 1'b1);
                1: step(1'b0, 32'h0104, 1'b0, 0, 0, 1'b0);
                default: step(1'b0, 32'h1FFF, 1'b0, 0, 0, 1'b0);
            endcase
        end

        // Allocation and first hit
        upd(32'h0104, 32'h0200, 1'b1);
        look(32'h0104);

        // Counter saturation both ways
        repeat (3) upd(32'h0104, 32'h0200, 1'b0);
        look(32'h0104);
        upd(32'h0104, 32'h0200, 1'b0);
        look(32'h0104);
        repeat (4) upd(32'h0104, 32'h0200, 1'b1);
        look(32'h0104);
        upd(32'h0104, 32'h0200, 1'b0);
        look(32'h0104);

        // Aliasing in set 0x104 and LRU replacement
        upd(32'h0304, 32'h0400, 1'b1);
        look(32'h0104);
        look(32'h0304);
        upd(32'h0104, 32'h0200, 1'b1);
        upd(32'h0504, 32'h0600, 1'b1);
        look(32'h0104);
        look(32'h0304);
        look(32'h0504);
        upd(32'h0904, 32'h0000, 1'b0);
        look(32'h0904);

        // Same-cycle lookup and update are read-first
        step(1'b0, 32'h0104, 1'b1, 32'h0104, 32'h0300, 1'b1);
        look(32'h0104);

        // Back-to-back updates to one set
        upd(32'h0AAA, 32'h0123, 1'b1);
        upd(32'h0CAA, 32'h0456, 1'b1);
        upd(32'h0AAA, 32'h0789, 1'b1);
        upd(32'h0EAA, 32'h0321, 1'b1);
        look(32'h0AAA);
        look(32'h0CAA);
        look(32'h0EAA);

        // Randomized traffic over a few crowded sets
        for (int i = 0; i < 600; i++) begin
            int lpc, upc;
            upc = rand_pc();
            lpc = ($urandom_range(3, 0) == 0) ? upc : rand_pc();
            step(1'b0, lpc, ($urandom_range(1, 0) == 1), upc,
                 int'($urandom_range(8191, 0)), ($urandom_range(9, 0) < 7));
        end

        // Reset pulse in RUN: sweep again, earlier entries must be gone
        step(1'b1, 32'h0104, 1'b1, 32'h0104, 32'h0222, 1'b1);
        for (int i = 0; i < SETS; i++) begin
            step(1'b0, 32'h0104, (i == 20), 32'h0104, 32'h0555, 1'b1);
        end
        look(32'h0104);
        look(32'h0504);
        look(32'h0AAA);
        for (int i = 0; i < 40; i++) look(rand_pc());
        upd(32'h0104, 32'h0200, 1'b1);
        look(32'h0104);

        // Drain the scoreboard with a bounded wait
        @(negedge CLK);
        upd_en = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual %0d responses outstanding, required 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_predict.md
# btb_predict

Parametrised, 2-way set-associative branch target buffer with 2-bit saturating direction counters, replacing the direct-mapped, valid/tag/target-only fetch predictor. The fetch stage presents `pcF` and receives a registered target/direction prediction one cycle later. The execute stage writes back resolved branches through a single update port. A built-in init sequencer clears all valid bits after reset, so no memory preload file is required.

## Interface
Parameters:
- `PC_W`, default 13: word-address PC width; byte bits [1:0] are already stripped.
- `IDX_W`, default 9: set-index width, giving 2^IDX_W sets; `TAG_W = PC_W - IDX_W`, which must be ≥ 1.
- `CNT_INIT`, default 2'b10: counter value written on allocation (weakly taken).

Ports:
- `CLK`  in  1: clock; all state changes on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `pcF`  in  PC_W: lookup PC; index `pcF[IDX_W-1:0]`, tag `pcF[PC_W-1:IDX_W]`.
- `hit_predict`  out  1: the looked-up PC is present in the BTB.
- `pred_taken`  out  1: `hit_predict` and the hit way's counter bit 1.
- `prepc`  out  PC_W: stored target of the hit way; 0 when there is no hit.
- `ready`  out  1: init sweep finished; lookups and updates are live.
- `upd_en`  in  1: resolved-branch update strobe from execute.
- `upd_pc`  in  PC_W: PC of the resolved branch.
- `upd_target`  in  PC_W: resolved target.
- `upd_taken`  in  1: resolved direction.

## Operation
- Entry fields: valid (1 bit), tag (TAG_W), target (PC_W), counter (2 bits). Each set also has one LRU bit, where 0 means way 0 is least recent.
- The FSM has two states: INIT and RUN.
  - `RST` moves the FSM to INIT and sets the sweep index to 0.
  - In INIT, the block clears the valid bits of both ways and the LRU bit at the sweep index, one set per cycle.
  - After it clears set 2^IDX_W−1, the FSM moves to RUN.
  - `RST` asserted while in RUN restarts INIT from index 0.
- In INIT, `ready`=0, lookup outputs are forced to miss, and `upd_en` is ignored with nothing queued.
- Lookup (RUN):
  - Compare both ways of set `pcF[IDX_W-1:0]`.
  - If both ways hit, which is illegal, way 0 wins.
- Update (RUN, `upd_en`=1):
  - **Hit way w, taken:** counter = min(cnt+1, 3); target = `upd_target`.
  - **Hit way w, not taken:** counter = max(cnt−1, 0); target is unchanged.
  - **Miss, taken:** allocate into the LRU way with valid=1, tag, target, counter=`CNT_INIT`.
  - **Miss, not taken:** no write, and LRU is unchanged.
  - Any hit or allocation sets LRU to point at the other way. Lookups never touch LRU.
- Counter arithmetic is 2-bit saturating; it never wraps from 3 to 0 or from 0 to 3.

## Timing
- Reset values: `hit_predict`=0, `pred_taken`=0, `prepc`=0, `ready`=0.
- `ready` rises on the edge after the last INIT sweep write: 2^IDX_W cycles after the edge that samples `RST`, which is 512 cycles at the defaults.
- Lookup latency is 1: `pcF` sampled at edge N drives the outputs from edge N until edge N+1. The outputs are registered, with no combinational path from `pcF`.
- Update latency is 1: an update sampled at edge N is visible to a lookup sampled at edge N+1.
- Same-set lookup and update in the same cycle are read-first: the lookup returns pre-update contents, with no bypass.
- The update path reads its own set in the same cycle it writes it, so back-to-back updates to the same set must be correct. The RAM is therefore read-asynchronous/write-synchronous, or the update port is forwarded.

## Structure
- Package `btb_pkg`:
  - counter encodings SNT=0, WNT=1, WT=2, ST=3;
  - FSM state encoding;
  - entry field offset/width functions of PC_W/IDX_W.
- Sub-module `btb_way`: one way's storage.
  - Per-set entry array with one lookup read port, one update read port and one write port.
  - Valid bits are held in flops so the INIT sweep can clear them.
  - Instantiated twice.
- The top level holds the FSM, sweep counter, LRU array, hit/replace logic and output registers.

## Test plan
- Reset with defaults: `ready` is 0 for exactly 512 cycles, then 1. Lookups of 0x0000, 0x0104 and 0x1FFF during INIT give `hit_predict`=0 and `prepc`=0.
- Taken update with pc=0x0104, target=0x0200, then lookup 0x0104 on the next cycle → `hit_predict`=1, `prepc`=0x0200, `pred_taken`=1 (counter 2).
- Counter saturation:
  - Three not-taken updates to 0x0104 → counter 0; lookup gives hit=1 and `pred_taken`=0.
  - Then four taken updates → counter 3 with no wrap.
  - Then one not-taken update → `pred_taken` stays 1.
- Aliasing and LRU:
  - Taken updates to 0x0104 then 0x0304 (same set 0x104, tags 0 and 1) → both hit.
  - Taken update to 0x0104, then allocate 0x0504 → it evicts 0x0304.
  - Lookups: 0x0104 hits, 0x0304 misses, 0x0504 hits.
- Same-cycle lookup of 0x0104 with a taken update of 0x0104 (target 0x0300) into an existing entry → that lookup returns the old target 0x0200; the next cycle returns 0x0300.
- `RST` pulsed for one cycle while in RUN with entries present → `ready`=0 for 512 cycles; every earlier entry misses afterward; an `upd_en` during INIT is dropped.
